// File: rtl/cla_pkg.sv
// Shared constants and elaboration-time helpers for the carry-look-ahead adder.
package cla_pkg;

  localparam int unsigned CLA_GROUP_DEFAULT = 4;

  // True when the operand width splits evenly into at least one look-ahead group.
  function automatic bit cla_width_ok(input int unsigned n, input int unsigned grp);
    return (grp != 0) && (n >= grp) && ((n % grp) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit first-level look-ahead block: expanded internal carries, sum slice,
// and group propagate/generate for the second-level network.
module cla_group
  import cla_pkg::*;
#(
  parameter int unsigned GROUP = CLA_GROUP_DEFAULT
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum_c,
  output logic             pg_c,
  output logic             gg_c
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;
  logic             prod;
  logic             acc;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is a flat sum of products over p/g/cin; no carry feeds another.
  always_comb begin
    c    = '0;
    prod = 1'b0;
    acc  = 1'b0;
    c[0] = cin;
    for (int i = 1; i <= int'(GROUP); i++) begin
      prod = cin;
      for (int m = 0; m < i; m++) prod = prod & p[m];
      acc = prod;
      for (int j = 0; j < i; j++) begin
        prod = g[j];
        for (int m = j + 1; m < i; m++) prod = prod & p[m];
        acc = acc | prod;
      end
      c[i] = acc;
    end
  end

  // Group generate is the same expansion without the carry-in term.
  always_comb begin
    gg_c = 1'b0;
    for (int j = 0; j < int'(GROUP); j++) begin
      logic term;
      term = g[j];
      for (int m = j + 1; m < int'(GROUP); m++) term = term & p[m];
      gg_c = gg_c | term;
    end
  end

  assign pg_c  = &p;
  assign sum_c = p ^ c[GROUP-1:0];

endmodule

// File: rtl/carry_look_ahead_adder.sv
// N-bit two-level carry-look-ahead adder with registered sum/carry_out.
// Define CLA_INPUT_REG_EN to add an input register stage (2-clock latency).
module carry_look_ahead_adder
  import cla_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned GROUP = CLA_GROUP_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         carry_out
);

  localparam int unsigned NG = N / GROUP;

  generate
    if (!cla_width_ok(N, GROUP)) begin : g_width_check
      $error("carry_look_ahead_adder: N must be a non-zero multiple of GROUP");
    end
  endgenerate

  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic          op_cin;

`ifdef CLA_INPUT_REG_EN
  // Operand capture stage; cleared together with the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      op_cin <= 1'b0;
    end else begin
      op_a   <= a;
      op_b   <= b;
      op_cin <= cin;
    end
  end
`else
  assign op_a   = a;
  assign op_b   = b;
  assign op_cin = cin;
`endif

  logic [NG-1:0] pg;
  logic [NG-1:0] gg;
  logic [NG:0]   c_grp;
  logic [N-1:0]  sum_c;

  generate
    for (genvar k = 0; k < int'(NG); k++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
        .a     (op_a[k*GROUP +: GROUP]),
        .b     (op_b[k*GROUP +: GROUP]),
        .cin   (c_grp[k]),
        .sum_c (sum_c[k*GROUP +: GROUP]),
        .pg_c  (pg[k]),
        .gg_c  (gg[k])
      );
    end
  endgenerate

  logic prod;
  logic acc;

  // Second-level look-ahead: every group carry-in is expanded from PG/GG and cin.
  always_comb begin
    c_grp    = '0;
    prod     = 1'b0;
    acc      = 1'b0;
    c_grp[0] = op_cin;
    for (int k = 1; k <= int'(NG); k++) begin
      prod = op_cin;
      for (int m = 0; m < k; m++) prod = prod & pg[m];
      acc = prod;
      for (int j = 0; j < k; j++) begin
        prod = gg[j];
        for (int m = j + 1; m < k; m++) prod = prod & pg[m];
        acc = acc | prod;
      end
      c_grp[k] = acc;
    end
  end

  // Result register; reset wins over any operand value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      sum       <= sum_c;
      carry_out <= c_grp[NG];
    end
  end

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Self-checking bench: directed corner cases plus random vectors against an
// arithmetic reference model with a pipeline-latency shadow.
module tb_carry_look_ahead_adder;

  localparam int unsigned N = 16;
`ifdef CLA_INPUT_REG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic [N-1:0] sum;
  logic         carry_out;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  logic [N:0]   exp_out = '0;
  logic [N-1:0] m_a     = '0;
  logic [N-1:0] m_b     = '0;
  logic         m_cin   = 1'b0;

  carry_look_ahead_adder #(.N(N), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  function automatic logic [N:0] ref_add(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic c);
    return (N+1)'(x) + (N+1)'(y) + (N+1)'(c);
  endfunction

  // Drive one cycle of inputs, advance past the edge, update the model's view.
  task automatic step(input logic [N-1:0] va, input logic [N-1:0] vb,
                      input logic vc, input logic vr);
    a = va; b = vb; cin = vc; rst = vr;
    @(posedge clk);
    #1;
`ifdef CLA_INPUT_REG_EN
    exp_out = vr ? '0 : ref_add(m_a, m_b, m_cin);
    m_a   = vr ? '0 : va;
    m_b   = vr ? '0 : vb;
    m_cin = vr ? 1'b0 : vc;
`else
    exp_out = vr ? '0 : ref_add(va, vb, vc);
`endif
  endtask

  // Hold one vector long enough to traverse the pipeline.
  task automatic hold(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vc);
    for (int i = 0; i < int'(LAT); i++) step(va, vb, vc, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < int'(LAT); i++) step(16'h1234, 16'h1111, 1'b1, 1'b1);
    n_checks++;
    if ({carry_out, sum} !== 17'h0_0000) begin
      n_fails++;
      $display("FAIL reset_state: got %h expected %h", {carry_out, sum}, 17'h0_0000);
    end
    hold(16'h1234, 16'h1111, 1'b1);
    n_checks++;
    if ({carry_out, sum} !== 17'h0_2346) begin
      n_fails++;
      $display("FAIL reset_release: got %h expected %h", {carry_out, sum}, 17'h0_2346);
    end
  endtask

  task automatic test_counting();
    for (int k = 1; k <= 20; k++) begin
      step(N'(k), N'(k), 1'b0, 1'b0);
      n_checks++;
      if ({carry_out, sum} !== exp_out) begin
        n_fails++;
        $display("FAIL count_sweep k=%0d: got %h expected %h", k, {carry_out, sum}, exp_out);
      end
    end
    hold(16'd7, 16'd7, 1'b0);
    n_checks++;
    if ({carry_out, sum} !== 17'h0_000E) begin
      n_fails++;
      $display("FAIL count_k7: got %h expected %h", {carry_out, sum}, 17'h0_000E);
    end
  endtask

  task automatic test_corners();
    logic [N:0] want [5];
    logic [N-1:0] va [5];
    logic [N-1:0] vb [5];
    logic         vc [5];
    va[0] = 16'hFFFF; vb[0] = 16'h0000; vc[0] = 1'b1; want[0] = 17'h1_0000;
    va[1] = 16'h8000; vb[1] = 16'h8000; vc[1] = 1'b0; want[1] = 17'h1_0000;
    va[2] = 16'hFFFF; vb[2] = 16'hFFFF; vc[2] = 1'b1; want[2] = 17'h1_FFFF;
    va[3] = 16'h000F; vb[3] = 16'h0001; vc[3] = 1'b0; want[3] = 17'h0_0010;
    va[4] = 16'h0FFF; vb[4] = 16'h0001; vc[4] = 1'b0; want[4] = 17'h0_1000;
    for (int i = 0; i < 5; i++) begin
      hold(va[i], vb[i], vc[i]);
      n_checks++;
      if ({carry_out, sum} !== want[i]) begin
        n_fails++;
        $display("FAIL corner_%0d a=%h b=%h cin=%b: got %h expected %h",
                 i, va[i], vb[i], vc[i], {carry_out, sum}, want[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      logic rst_pulse;
      rst_pulse = (i == 5000);
      step(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)), rst_pulse);
      n_checks++;
      if ({carry_out, sum} !== exp_out) begin
        n_fails++;
        $display("FAIL random i=%0d rst=%b: got %h expected %h", i, rst_pulse,
                 {carry_out, sum}, exp_out);
      end
      if (rst_pulse) begin
        n_checks++;
        if ({carry_out, sum} !== 17'h0_0000) begin
          n_fails++;
          $display("FAIL midstream_reset: got %h expected %h", {carry_out, sum}, 17'h0_0000);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] va;
    logic [N-1:0] vb;
    for (int i = 0; i < 64; i++) begin
      va = N'($urandom);
      vb = ~va;
      step(va, vb, 1'(i & 1), 1'b0);
      n_checks++;
      if ({carry_out, sum} !== exp_out) begin
        n_fails++;
        $display("FAIL back_to_back i=%0d: got %h expected %h", i, {carry_out, sum}, exp_out);
      end
    end
  endtask

  initial begin
    a = '0; b = '0; cin = 1'b0; rst = 1'b1;
    #2;
    test_reset();
    test_counting();
    test_corners();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
